// File: rtl/gdc_pkg.sv
// Shared types for the garage door supervisor: state and direction encodings
// plus the helper that picks the travel direction after a stop.
package gdc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT    = 3'd0,
        S_CLOSED  = 3'd1,
        S_OPENING = 3'd2,
        S_OPEN    = 3'd3,
        S_CLOSING = 3'd4,
        S_STOPPED = 3'd5,
        S_DEAD    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Resuming after a stop always travels opposite to the interrupted motion.
    function automatic state_t resume_target(dir_t last_dir);
        return (last_dir == DIR_UP) ? S_CLOSING : S_OPENING;
    endfunction

endpackage

// File: rtl/gdc_timer.sv
// Clearable, saturating cycle counter; expired flags the last cycle of a
// window of `limit` cycles (a zero limit never expires).
module gdc_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (limit != '0) && (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/garage_door_supervisor.sv
// Garage door sequencer: merges the two request buttons into a single press
// event and drives the motor enables as a Moore decode of the state register.
module garage_door_supervisor
    import gdc_pkg::*;
#(
    parameter int TRAVEL_TIMEOUT = 1000,
    parameter int AUTO_CLOSE     = 5000,
    parameter int DEAD_CYC       = 8,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_remote,
    input  logic               req_wall,
    input  logic               up_max,
    input  logic               down_max,
    input  logic               obstacle,
    output logic               up_m,
    output logic               down_m,
    output logic               fault,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] TRAVEL_LIM = CNT_W'(TRAVEL_TIMEOUT);
    localparam logic [CNT_W-1:0] CLOSE_LIM  = CNT_W'(AUTO_CLOSE);
    localparam logic [CNT_W-1:0] DEAD_LIM   = CNT_W'(DEAD_CYC);

    state_t     state_q, state_d;
    state_t     pending_q, pending_d;
    dir_t       last_dir_q, last_dir_d;
    logic       req_q, req_d;
    logic       req_any, press;
    logic       timer_clr, timer_expired;
    logic [CNT_W-1:0] timer_limit;
    state_t     target, dead_pending;

    gdc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_comb begin
        timer_limit = '0;
        case (state_q)
            S_OPENING, S_CLOSING: timer_limit = TRAVEL_LIM;
            S_OPEN:               timer_limit = CLOSE_LIM;
            S_DEAD:               timer_limit = DEAD_LIM;
            default:              timer_limit = '0;
        endcase
    end

    always_comb begin
        req_any      = req_remote | req_wall;
        press        = req_any & ~req_q;
        req_d        = req_any;
        state_d      = state_q;
        pending_d    = pending_q;
        last_dir_d   = last_dir_q;
        target       = resume_target(last_dir_q);
        dead_pending = (obstacle && pending_q == S_CLOSING) ? S_OPENING : pending_q;

        case (state_q)
            S_INIT: begin
                if (up_max && down_max) state_d = S_FAULT;
                else if (down_max)      state_d = S_CLOSED;
                else if (up_max)        state_d = S_OPEN;
                else                    state_d = S_STOPPED;
            end
            S_CLOSED: begin
                if (press) state_d = S_OPENING;
            end
            S_OPENING: begin
                if (up_max) begin
                    state_d = S_OPEN;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end else if (press) begin
                    state_d    = S_STOPPED;
                    last_dir_d = DIR_UP;
                end
            end
            S_OPEN: begin
                // A blocked beam suppresses both manual and automatic closing.
                if (!obstacle && (press || timer_expired)) state_d = S_CLOSING;
            end
            S_CLOSING: begin
                if (down_max) begin
                    state_d = S_CLOSED;
                end else if (obstacle) begin
                    state_d   = S_DEAD;
                    pending_d = S_OPENING;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end else if (press) begin
                    state_d    = S_STOPPED;
                    last_dir_d = DIR_DOWN;
                end
            end
            S_STOPPED: begin
                if (press && !(target == S_CLOSING && obstacle)) begin
                    state_d   = S_DEAD;
                    pending_d = target;
                end
            end
            S_DEAD: begin
                pending_d = dead_pending;
                if (timer_expired) state_d = dead_pending;
            end
            default: state_d = S_FAULT;
        endcase

        // Both limit switches closed at once means a wiring or sensor fault.
        if (state_q != S_INIT && state_q != S_FAULT && up_max && down_max) begin
            state_d = S_FAULT;
        end

        timer_clr = (state_d != state_q) || (state_q == S_OPEN && obstacle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            pending_q  <= S_OPENING;
            last_dir_q <= DIR_DOWN;
            req_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_dir_q <= last_dir_d;
            req_q      <= req_d;
        end
    end

    assign up_m    = (state_q == S_OPENING);
    assign down_m  = (state_q == S_CLOSING);
    assign fault   = (state_q == S_FAULT);
    assign state_o = state_q;

endmodule
